jt1943_vrom_arb: RTL and testbench
==================================

// Module: jt1943_vrom_arb
// PURPOSE
// - Shares one SDRAM read port among the six 1943 video ROM requesters: char, scroll1, scroll2, map1, map2, obj.
// - Each requester presents a word address; the block fetches the 16-bit word and holds it with a per-slot ok flag.
// - Sits between the video top level and the SDRAM controller; the video side never sees SDRAM timing.
// PARAMETERS
// - AW          22       SDRAM word-address width
// - CHAR_OFFSET 22'h0    base word address of char ROM region
// - SCR1_OFFSET 22'h0    base of scroll1 tile ROM; MAP1_OFFSET, MAP2_OFFSET, SCR2_OFFSET, OBJ_OFFSET: same meaning per slot, default 22'h0
// PORTS
// - clk          in   1   system clock
// - rst          in   1   synchronous reset, active-high
// - char_addr    in  14   char ROM word address;  char_data out 16; char_ok out 1
// - scr1_addr    in  17   scroll1 tile address;   scr1_data out 16; scr1_ok out 1
// - scr2_addr    in  15   scroll2 tile address;   scr2_data out 16; scr2_ok out 1
// - map1_addr    in  14   scroll1 map address;    map1_data out 16; map1_ok out 1
// - map2_addr    in  14   scroll2 map address;    map2_data out 16; map2_ok out 1
// - obj_addr     in  17   object ROM address;     obj_data  out 16; obj_ok  out 1
// - sdram_req    out  1   read request, held until sdram_ack
// - sdram_addr   out AW   word address = slot OFFSET + zero-extended slot address (mod 2^AW)
// - sdram_ack    in   1   controller accepted request
// - sdram_rdy    in   1   one-cycle strobe: data_read valid
// - data_read    in  16   SDRAM read data
// BEHAVIOUR
// - Reset: all *_ok=0, *_data=0, sdram_req=0, sdram_addr=0, FSM=IDLE, every slot marked pending, arbitration pointer=slot 0 (char).
// - Slot pending when current addr != last fetched addr, or slot never fetched. Address change -> *_ok falls on the next clock edge; *_data holds old word.
// - FSM IDLE: if any slot pending, grant one, register its addr/slot index, sdram_req=1 -> WAIT_ACK. Decision takes one cycle.
// - WAIT_ACK: on sdram_ack, sdram_req=0 -> WAIT_RDY. ack and rdy in the same cycle: treat as both, go straight to IDLE with data captured.
// - WAIT_RDY: on sdram_rdy, if granted slot's current addr equals captured addr: latch data_read, ok=1 next cycle; else discard, slot stays pending. -> IDLE.
// - Minimum latency addr change -> ok=1: 3 cycles beyond SDRAM ack/rdy latency.
// - sdram_addr stable from req rise until rdy. No new request issued while one outstanding.
// - Reset mid-fetch: FSM to IDLE at once, sdram_req drops; a stray sdram_rdy/ack while IDLE is ignored.
// - Slot index order: 0 char,1 scr1,2 scr2,3 map1,4 map2,5 obj.
// CONFIGURATION
// - JT1943_VROM_RR_EN defined: round-robin; search starts at slot after last granted, wraps 5->0.
// - Undefined: fixed priority, lowest index wins (char highest, obj lowest); pointer unused.
// STRUCTURE
// - Package jt1943_vrom_pkg: slot index localparams, NSLOTS=6, FSM state encoding (IDLE, WAIT_ACK, WAIT_RDY).
// - Sub-module jt1943_vrom_slot (x6): address-change compare, fetched-valid bit, data/ok registers, pending output; parameterised address width.
// - Top: arbiter, FSM, offset adder, slot mux.
// TESTING
// - Reset, then char_addr=14'h0010 only, SDRAM model ack+1 / rdy+4 returning 16'hA5A5 -> sdram_addr=CHAR_OFFSET+22'h10, char_ok=1, char_data=16'hA5A5.
// - All six addresses change in same cycle -> six fetches, each slot exactly once; RR order 0..5 from reset; fixed-priority order 0..5 too, but with char changing every fetch obj starves (fixed) / is served within 6 grants (RR).
// - scr1_addr changes 17'h00100->17'h00101 while fetch outstanding -> returned word discarded, scr1_ok stays 0, second fetch at 17'h00101 issued, then ok=1.
// - ack and rdy asserted same cycle -> data captured, FSM back to IDLE, next pending slot requested one cycle later.
// - rst pulsed in WAIT_RDY, then rdy strobe -> sdram_req=0, all ok=0, data ignored, all slots refetched after reset.
// - OBJ_OFFSET=22'h3F_FFF0, obj_addr=17'h20 -> sdram_addr wraps to 22'h000010.

Source files
------------

// File: rtl/jt1943_vrom_pkg.sv
// Shared constants for the 1943 video ROM arbiter: slot indices, widths, FSM encoding.
// Optional round-robin arbitration is enabled with JT1943_VROM_RR_EN.
package jt1943_vrom_pkg;

   localparam int NSLOTS = 6;
   localparam int IDXW   = 3;
   localparam int MAXW   = 17;

   localparam logic [IDXW-1:0] SLOT_CHAR = 3'd0;
   localparam logic [IDXW-1:0] SLOT_SCR1 = 3'd1;
   localparam logic [IDXW-1:0] SLOT_SCR2 = 3'd2;
   localparam logic [IDXW-1:0] SLOT_MAP1 = 3'd3;
   localparam logic [IDXW-1:0] SLOT_MAP2 = 3'd4;
   localparam logic [IDXW-1:0] SLOT_OBJ  = 3'd5;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_ACK = 2'd1;
   localparam logic [1:0] ST_WAIT_RDY = 2'd2;

   typedef logic [MAXW-1:0] slot_addr_t;
   typedef logic [15:0]     word_t;

   function automatic logic [IDXW-1:0] slot_wrap(input logic [IDXW-1:0] s);
      return (s == SLOT_OBJ) ? SLOT_CHAR : s + 3'd1;
   endfunction

endpackage

// File: rtl/jt1943_vrom_arb_if.sv
// Video-side ROM ports plus the SDRAM read port of the arbiter.
// slave = arbiter view, master = video/SDRAM environment view.
interface jt1943_vrom_arb_if #(parameter int AW = 22);

   logic [13:0]   char_addr;
   logic [15:0]   char_data;
   logic          char_ok;
   logic [16:0]   scr1_addr;
   logic [15:0]   scr1_data;
   logic          scr1_ok;
   logic [14:0]   scr2_addr;
   logic [15:0]   scr2_data;
   logic          scr2_ok;
   logic [13:0]   map1_addr;
   logic [15:0]   map1_data;
   logic          map1_ok;
   logic [13:0]   map2_addr;
   logic [15:0]   map2_data;
   logic          map2_ok;
   logic [16:0]   obj_addr;
   logic [15:0]   obj_data;
   logic          obj_ok;

   logic          sdram_req;
   logic [AW-1:0] sdram_addr;
   logic          sdram_ack;
   logic          sdram_rdy;
   logic [15:0]   data_read;

   modport slave (
      input  char_addr, scr1_addr, scr2_addr, map1_addr, map2_addr, obj_addr,
      output char_data, scr1_data, scr2_data, map1_data, map2_data, obj_data,
      output char_ok, scr1_ok, scr2_ok, map1_ok, map2_ok, obj_ok,
      output sdram_req, sdram_addr,
      input  sdram_ack, sdram_rdy, data_read
   );

   modport master (
      output char_addr, scr1_addr, scr2_addr, map1_addr, map2_addr, obj_addr,
      input  char_data, scr1_data, scr2_data, map1_data, map2_data, obj_data,
      input  char_ok, scr1_ok, scr2_ok, map1_ok, map2_ok, obj_ok,
      input  sdram_req, sdram_addr,
      output sdram_ack, sdram_rdy, data_read
   );

endinterface

// File: rtl/jt1943_vrom_slot.sv
// One requester slot: remembers the last fetched address and word, flags pending/ok.
// ok drops the edge after the address moves away and rises the edge a matching word lands.
module jt1943_vrom_slot
   import jt1943_vrom_pkg::*;
#(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] addr_i,
   input  logic         rdy_hit_i,
   input  logic [W-1:0] cap_addr_i,
   input  word_t        data_read_i,
   output logic         pending_o,
   output word_t        data_o,
   output logic         ok_o
);

   logic [W-1:0] last_q, last_d;
   logic         fetched_q, fetched_d;
   word_t        data_q, data_d;
   logic         ok_q, ok_d;
   logic         same;
   logic         load;

   assign same = fetched_q && (addr_i == last_q);
   // A word is only kept if the requester still wants the address it was fetched for
   assign load = rdy_hit_i && (addr_i == cap_addr_i);

   always_comb begin
      last_d    = last_q;
      fetched_d = fetched_q;
      data_d    = data_q;
      ok_d      = same;
      if (load) begin
         last_d    = addr_i;
         fetched_d = 1'b1;
         data_d    = data_read_i;
         ok_d      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q    <= '0;
         fetched_q <= 1'b0;
         data_q    <= '0;
         ok_q      <= 1'b0;
      end else begin
         last_q    <= last_d;
         fetched_q <= fetched_d;
         data_q    <= data_d;
         ok_q      <= ok_d;
      end
   end

   assign pending_o = !same;
   assign data_o    = data_q;
   assign ok_o      = ok_q;

endmodule

// File: rtl/jt1943_vrom_arb.sv
// Six-way video ROM arbiter onto a single SDRAM read port (one request outstanding at a time).
// Fixed priority by default; define JT1943_VROM_RR_EN for round-robin slot selection.
module jt1943_vrom_arb
   import jt1943_vrom_pkg::*;
#(
   parameter int            AW          = 22,
   parameter logic [AW-1:0] CHAR_OFFSET = '0,
   parameter logic [AW-1:0] SCR1_OFFSET = '0,
   parameter logic [AW-1:0] MAP1_OFFSET = '0,
   parameter logic [AW-1:0] MAP2_OFFSET = '0,
   parameter logic [AW-1:0] SCR2_OFFSET = '0,
   parameter logic [AW-1:0] OBJ_OFFSET  = '0
) (
   input  logic               clk,
   input  logic               rst,
   jt1943_vrom_arb_if.slave   bus
);

   logic [NSLOTS-1:0] pending;
   logic [NSLOTS-1:0] hit_vec;
   slot_addr_t        slot_addr [NSLOTS];

   logic [1:0]        state_q, state_d;
   logic [IDXW-1:0]   slot_q, slot_d;
   slot_addr_t        cap_q, cap_d;
   logic              req_q, req_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              rdy_hit;
   logic [IDXW-1:0]   sel;
   logic [AW-1:0]     sel_off;

   assign slot_addr[SLOT_CHAR] = MAXW'(bus.char_addr);
   assign slot_addr[SLOT_SCR1] = MAXW'(bus.scr1_addr);
   assign slot_addr[SLOT_SCR2] = MAXW'(bus.scr2_addr);
   assign slot_addr[SLOT_MAP1] = MAXW'(bus.map1_addr);
   assign slot_addr[SLOT_MAP2] = MAXW'(bus.map2_addr);
   assign slot_addr[SLOT_OBJ]  = MAXW'(bus.obj_addr);

`ifdef JT1943_VROM_RR_EN
   logic [IDXW-1:0] ptr_q, ptr_d;

   // Search begins at the slot after the last grant and wraps obj -> char
   always_comb begin
      logic [IDXW-1:0] idx;
      logic            found;
      sel   = SLOT_CHAR;
      found = 1'b0;
      idx   = ptr_q;
      for (int k = 0; k < NSLOTS; k++) begin
         if (!found && pending[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
         idx = slot_wrap(idx);
      end
   end
`else
   always_comb begin
      sel = SLOT_CHAR;
      for (int i = NSLOTS - 1; i >= 0; i--) begin
         if (pending[i]) sel = IDXW'(i);
      end
   end
`endif

   always_comb begin
      case (sel)
         SLOT_CHAR: sel_off = CHAR_OFFSET;
         SLOT_SCR1: sel_off = SCR1_OFFSET;
         SLOT_SCR2: sel_off = SCR2_OFFSET;
         SLOT_MAP1: sel_off = MAP1_OFFSET;
         SLOT_MAP2: sel_off = MAP2_OFFSET;
         default:   sel_off = OBJ_OFFSET;
      endcase
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      cap_d   = cap_q;
      req_d   = req_q;
      addr_d  = addr_q;
      rdy_hit = 1'b0;
`ifdef JT1943_VROM_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|pending) begin
               slot_d  = sel;
               cap_d   = slot_addr[sel];
               addr_d  = sel_off + AW'(slot_addr[sel]);
               req_d   = 1'b1;
               state_d = ST_WAIT_ACK;
`ifdef JT1943_VROM_RR_EN
               ptr_d   = slot_wrap(sel);
`endif
            end
         end
         ST_WAIT_ACK: begin
            if (bus.sdram_ack) begin
               req_d = 1'b0;
               // Controllers that answer in the ack cycle skip WAIT_RDY entirely
               if (bus.sdram_rdy) begin
                  rdy_hit = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT_RDY;
               end
            end
         end
         ST_WAIT_RDY: begin
            if (bus.sdram_rdy) begin
               rdy_hit = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         slot_q  <= SLOT_CHAR;
         cap_q   <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
`ifdef JT1943_VROM_RR_EN
         ptr_q   <= SLOT_CHAR;
`endif
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         cap_q   <= cap_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
`ifdef JT1943_VROM_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign bus.sdram_req  = req_q;
   assign bus.sdram_addr = addr_q;

   for (genvar i = 0; i < NSLOTS; i++) begin : g_hit
      assign hit_vec[i] = rdy_hit && (slot_q == IDXW'(i));
   end

   jt1943_vrom_slot #(.W(14)) u_char (
      .clk(clk), .rst(rst), .addr_i(bus.char_addr), .rdy_hit_i(hit_vec[SLOT_CHAR]),
      .cap_addr_i(cap_q[13:0]), .data_read_i(bus.data_read),
      .pending_o(pending[SLOT_CHAR]), .data_o(bus.char_data), .ok_o(bus.char_ok)
   );

   jt1943_vrom_slot #(.W(17)) u_scr1 (
      .clk(clk), .rst(rst), .addr_i(bus.scr1_addr), .rdy_hit_i(hit_vec[SLOT_SCR1]),
      .cap_addr_i(cap_q[16:0]), .data_read_i(bus.data_read),
      .pending_o(pending[SLOT_SCR1]), .data_o(bus.scr1_data), .ok_o(bus.scr1_ok)
   );

   jt1943_vrom_slot #(.W(15)) u_scr2 (
      .clk(clk), .rst(rst), .addr_i(bus.scr2_addr), .rdy_hit_i(hit_vec[SLOT_SCR2]),
      .cap_addr_i(cap_q[14:0]), .data_read_i(bus.data_read),
      .pending_o(pending[SLOT_SCR2]), .data_o(bus.scr2_data), .ok_o(bus.scr2_ok)
   );

   jt1943_vrom_slot #(.W(14)) u_map1 (
      .clk(clk), .rst(rst), .addr_i(bus.map1_addr), .rdy_hit_i(hit_vec[SLOT_MAP1]),
      .cap_addr_i(cap_q[13:0]), .data_read_i(bus.data_read),
      .pending_o(pending[SLOT_MAP1]), .data_o(bus.map1_data), .ok_o(bus.map1_ok)
   );

   jt1943_vrom_slot #(.W(14)) u_map2 (
      .clk(clk), .rst(rst), .addr_i(bus.map2_addr), .rdy_hit_i(hit_vec[SLOT_MAP2]),
      .cap_addr_i(cap_q[13:0]), .data_read_i(bus.data_read),
      .pending_o(pending[SLOT_MAP2]), .data_o(bus.map2_data), .ok_o(bus.map2_ok)
   );

   jt1943_vrom_slot #(.W(17)) u_obj (
      .clk(clk), .rst(rst), .addr_i(bus.obj_addr), .rdy_hit_i(hit_vec[SLOT_OBJ]),
      .cap_addr_i(cap_q[16:0]), .data_read_i(bus.data_read),
      .pending_o(pending[SLOT_OBJ]), .data_o(bus.obj_data), .ok_o(bus.obj_ok)
   );

endmodule

// File: tb/tb_jt1943_vrom_arb.sv
// Randomised and directed bench: SDRAM model serves a synthetic ROM, per-slot scoreboard
// queues hold the word each requester must eventually see with ok=1.
module tb_jt1943_vrom_arb;
   import jt1943_vrom_pkg::*;

   localparam int AW = 22;
   localparam logic [21:0] OFF [6] = '{22'h000000, 22'h040000, 22'h080000,
                                       22'h0C0000, 22'h100000, 22'h3FFFF0};
   localparam int WID [6] = '{14, 17, 15, 14, 14, 17};

   typedef struct { logic [16:0] a; logic [15:0] d; } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jt1943_vrom_arb_if #(.AW(AW)) bus ();

   jt1943_vrom_arb #(
      .AW(AW), .CHAR_OFFSET(OFF[0]), .SCR1_OFFSET(OFF[1]), .SCR2_OFFSET(OFF[2]),
      .MAP1_OFFSET(OFF[3]), .MAP2_OFFSET(OFF[4]), .OBJ_OFFSET(OFF[5])
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [16:0] a_tb [6];
   logic        ack_tb, rdy_tb;
   logic [15:0] dr_tb;
   logic [5:0]  okv, okp;
   logic [15:0] datv [6];

   assign bus.char_addr = a_tb[0][13:0];
   assign bus.scr1_addr = a_tb[1];
   assign bus.scr2_addr = a_tb[2][14:0];
   assign bus.map1_addr = a_tb[3][13:0];
   assign bus.map2_addr = a_tb[4][13:0];
   assign bus.obj_addr  = a_tb[5];
   assign bus.sdram_ack = ack_tb;
   assign bus.sdram_rdy = rdy_tb;
   assign bus.data_read = dr_tb;
   assign okv = {bus.obj_ok, bus.map2_ok, bus.map1_ok, bus.scr2_ok, bus.scr1_ok, bus.char_ok};
   assign datv[0] = bus.char_data;
   assign datv[1] = bus.scr1_data;
   assign datv[2] = bus.scr2_data;
   assign datv[3] = bus.map1_data;
   assign datv[4] = bus.map2_data;
   assign datv[5] = bus.obj_data;

   int checks = 0;
   int errors = 0;
   exp_t sbq [6][$];
   logic [21:0] glog [$];
   int gapq [$];
   int cyc = 0, last_rdy_cyc = 0, rdy_cnt = 0;
   logic force_en, rand_lat, chk_stable;
   logic [15:0] force_val;
   int ackd_set, rdyd_set;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [15:0] rom(input logic [21:0] a);
      return (a[15:0] * 16'd40503) ^ {10'd0, a[21:16]} ^ 16'h1357;
   endfunction

   function automatic logic [21:0] exp_addr(input int s, input logic [16:0] a);
      return OFF[s] + 22'(a);
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int s);
      exp_t e;
      e.a = a_tb[s];
      e.d = force_en ? force_val : rom(exp_addr(s, a_tb[s]));
      sbq[s].delete();
      sbq[s].push_back(e);
   endtask

   task automatic set_addr(input int s, input logic [16:0] a);
      logic [16:0] m;
      m = a & 17'((1 << WID[s]) - 1);
      if (m != a_tb[s]) begin
         a_tb[s] = m;
         push_exp(s);
      end
   endtask

   function automatic int outstanding();
      int n = 0;
      for (int s = 0; s < 6; s++) n += sbq[s].size();
      return n;
   endfunction

   task automatic wait_drain(input string nm);
      int n = 0;
      while (outstanding() != 0 && n < 3000) begin
         step();
         n++;
      end
      chk(nm, outstanding(), 0);
   endtask

   task automatic wait_grant(input string nm, input int cnt);
      int n = 0;
      while (glog.size() < cnt && n < 200) begin
         step();
         n++;
      end
      chk(nm, (glog.size() >= cnt) ? 1 : 0, 1);
   endtask

   // SDRAM controller model: one transaction at a time, ack/rdy a set number of cycles after req
   initial begin
      int k, ackd, rdyd;
      logic busy;
      logic [21:0] cur_a;
      ack_tb = 1'b0; rdy_tb = 1'b0; dr_tb = '0; busy = 1'b0;
      k = 0; ackd = 1; rdyd = 4; cur_a = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         ack_tb = 1'b0;
         rdy_tb = 1'b0;
         if (busy) begin
            k++;
            if (chk_stable) begin
               chk("sdram_addr_stable", bus.sdram_addr, cur_a);
               if (k > ackd) chk("req_low_after_ack", bus.sdram_req, 0);
            end
            if (k == ackd) ack_tb = 1'b1;
            if (k == rdyd) begin
               rdy_tb = 1'b1;
               dr_tb = force_en ? force_val : rom(cur_a);
               busy = 1'b0;
               last_rdy_cyc = cyc;
               rdy_cnt++;
            end
         end else if (bus.sdram_req) begin
            busy = 1'b1;
            k = 0;
            cur_a = bus.sdram_addr;
            glog.push_back(cur_a);
            gapq.push_back(cyc - last_rdy_cyc);
            if (rand_lat) begin
               ackd = $urandom_range(1, 3);
               rdyd = ackd + $urandom_range(0, 4);
            end else begin
               ackd = ackd_set;
               rdyd = rdyd_set;
            end
         end
      end
   end

   // Monitor: every ok rising edge must deliver the queued word for the slot's current address
   initial begin
      exp_t e;
      okp = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int s = 0; s < 6; s++) begin
            if (okv[s] && !okp[s]) begin
               if (sbq[s].size() == 0) begin
                  chk($sformatf("spurious_ok_slot%0d", s), 1, 0);
               end else begin
                  e = sbq[s].pop_front();
                  chk($sformatf("ok_addr_slot%0d", s), 32'(a_tb[s]), 32'(e.a));
                  chk($sformatf("ok_data_slot%0d", s), 32'(datv[s]), 32'(e.d));
               end
            end
         end
         okp = okv;
      end
   end

   initial begin
      int obj_seen;
      logic [21:0] obj_ga;
      for (int s = 0; s < 6; s++) a_tb[s] = '0;
      force_en = 1'b1; force_val = 16'hA5A5;
      rand_lat = 1'b0; chk_stable = 1'b1;
      ackd_set = 1; rdyd_set = 4;
      rst = 1'b1;
      a_tb[0] = 17'h00010;
      repeat (3) step();
      chk("rst_req", bus.sdram_req, 0);
      chk("rst_addr", bus.sdram_addr, 0);
      chk("rst_ok", okv, 0);
      for (int s = 0; s < 6; s++) chk($sformatf("rst_data%0d", s), datv[s], 0);

      // Char at 0x10 first, then every never-fetched slot in index order
      for (int s = 0; s < 6; s++) push_exp(s);
      rst = 1'b0;
      wait_drain("t1_drain");
      chk("t1_glog_size", glog.size(), 6);
      chk("t1_char_addr", glog[0], 22'h000010);
      for (int i = 1; i < 6; i++) chk($sformatf("t1_order%0d", i), glog[i], exp_addr(i, a_tb[i]));
      chk("t1_char_data", bus.char_data, 16'hA5A5);
      chk("t1_char_ok", bus.char_ok, 1);
      force_en = 1'b0;

      // All six change together
      glog.delete();
      set_addr(0, 17'h00123); set_addr(1, 17'h12345); set_addr(2, 17'h02345);
      set_addr(3, 17'h00ABC); set_addr(4, 17'h01DEF); set_addr(5, 17'h08000);
      wait_drain("t2_drain");
      chk("t2_glog_size", glog.size(), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t2_order%0d", i), glog[i], exp_addr(i, a_tb[i]));

      // Char moves after every grant: obj starves under fixed priority, served under round-robin
      glog.delete();
      set_addr(0, 17'h00200); set_addr(1, 17'h00300); set_addr(2, 17'h00400);
      set_addr(3, 17'h00500); set_addr(4, 17'h00600); set_addr(5, 17'h09000);
      for (int n = 0; n < 6; n++) begin
         wait_grant("t3_grant", n + 1);
         set_addr(0, 17'(17'h00201 + n));
      end
      obj_ga = exp_addr(5, a_tb[5]);
      obj_seen = 0;
      for (int i = 0; i < 6; i++) if (glog[i] == obj_ga) obj_seen = 1;
`ifdef JT1943_VROM_RR_EN
      chk("t3_rr_obj_served", obj_seen, 1);
`else
      chk("t3_fixed_obj_starved", obj_seen, 0);
`endif
      wait_drain("t3_drain");

      // scr1 moves while its fetch is outstanding: stale word dropped, refetched
      glog.delete();
      set_addr(1, 17'h00100);
      wait_grant("t4_grant1", 1);
      chk("t4_first_addr", glog[0], 22'h040100);
      set_addr(1, 17'h00101);
      begin
         int r0 = rdy_cnt;
         int n = 0;
         while (rdy_cnt == r0 && n < 50) begin step(); n++; end
      end
      step();
      chk("t4_scr1_ok_after_discard", bus.scr1_ok, 0);
      wait_grant("t4_grant2", 2);
      chk("t4_second_addr", glog[1], 22'h040101);
      wait_drain("t4_drain");

      // ack and rdy in the same cycle
      ackd_set = 2; rdyd_set = 2;
      glog.delete(); gapq.delete();
      set_addr(3, 17'h00111); set_addr(4, 17'h00222);
      wait_drain("t5_drain");
      chk("t5_glog_size", glog.size(), 2);
      chk("t5_next_req_gap", gapq[1], 2);

      // Reset while waiting for rdy; the late rdy must be ignored and all slots refetched
      ackd_set = 1; rdyd_set = 6;
      chk_stable = 1'b0;
      glog.delete();
      set_addr(0, 17'h00333);
      wait_grant("t6_grant", 1);
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      glog.delete();
      for (int s = 0; s < 6; s++) push_exp(s);
      chk("t6_rst_req", bus.sdram_req, 0);
      chk("t6_rst_ok", okv, 0);
      chk("t6_rst_char_data", bus.char_data, 0);
      wait_drain("t6_drain");
      chk("t6_refetch_count", glog.size(), 6);
      chk_stable = 1'b1;
      ackd_set = 1; rdyd_set = 4;

      // obj offset wraps modulo 2^AW
      glog.delete();
      set_addr(5, 17'h00020);
      wait_drain("t7_drain");
      chk("t7_glog_size", glog.size(), 1);
      chk("t7_wrap_addr", glog[0], 22'h000010);

      // Random address traffic with random SDRAM latency
      rand_lat = 1'b1;
      for (int it = 0; it < 300; it++) begin
         set_addr($urandom_range(0, 5), 17'($urandom));
         repeat ($urandom_range(1, 12)) step();
      end
      wait_drain("rand_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
